// File: rtl/die_select_encoder_pkg.sv
// Shared code constants, code typedef and input indexing for the dice-roller die-select encoder.
package die_select_pkg;

  typedef logic [3:0] die_code_t;

  localparam die_code_t DIE_D4   = 4'h0;
  localparam die_code_t DIE_D6   = 4'h1;
  localparam die_code_t DIE_D8   = 4'h2;
  localparam die_code_t DIE_D10  = 4'h3;
  localparam die_code_t DIE_D12  = 4'h4;
  localparam die_code_t DIE_D20  = 4'h5;
  localparam die_code_t DIE_TEST = 4'h7;
  localparam die_code_t DIE_NONE = 4'hF;

  localparam int unsigned NUM_INPUTS = 7;

  typedef enum logic [2:0] {
    IDX_D4   = 3'd0,
    IDX_D6   = 3'd1,
    IDX_D8   = 3'd2,
    IDX_D10  = 3'd3,
    IDX_D12  = 3'd4,
    IDX_D20  = 3'd5,
    IDX_TEST = 3'd6
  } die_idx_e;

  function automatic die_code_t idx_code(input die_idx_e idx);
    case (idx)
      IDX_D4:   return DIE_D4;
      IDX_D6:   return DIE_D6;
      IDX_D8:   return DIE_D8;
      IDX_D10:  return DIE_D10;
      IDX_D12:  return DIE_D12;
      IDX_D20:  return DIE_D20;
      IDX_TEST: return DIE_TEST;
      default:  return DIE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/die_select_encoder_cond.sv
// One-bit input conditioner: SYNC_STAGES-deep synchroniser, plus a per-input
// debouncer when DIESEL_DEBOUNCE_EN is defined.
module die_input_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end

`ifdef DIESEL_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          deb;

  // Accept the new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync[SYNC_STAGES-1] != deb) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync[SYNC_STAGES-1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  assign dout = deb;
`else
  assign dout = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/die_select_encoder.sv
// Registered one-hot-to-binary die-select encoder; illegal combinations yield DIE_NONE.
// Optional input debounce is enabled by defining DIESEL_DEBOUNCE_EN.
module die_select_encoder
  import die_select_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buttonD4,
  input  logic       buttonD6,
  input  logic       buttonD8,
  input  logic       buttonD10,
  input  logic       buttonD12,
  input  logic       buttonD20,
  input  logic       switchTest,
  output logic [3:0] dieSelect,
  output logic       selValid
);

  logic [NUM_INPUTS-1:0] raw;
  logic [NUM_INPUTS-1:0] cond;
  logic [2:0]            popcnt;
  die_code_t             code;

  assign raw = {switchTest, buttonD20, buttonD12, buttonD10, buttonD8, buttonD6, buttonD4};

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cond
    die_input_cond #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw[g]),
      .dout (cond[g])
    );
  end

  // No priority: the code is taken from the active input only when it is the sole one.
  always_comb begin
    popcnt = '0;
    code   = DIE_NONE;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      popcnt = popcnt + 3'(cond[i]);
    end
    if (popcnt == 3'd1) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (cond[i]) code = idx_code(die_idx_e'(i[2:0]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dieSelect <= DIE_NONE;
      selValid  <= 1'b0;
    end else begin
      dieSelect <= code;
      selValid  <= (popcnt == 3'd1);
    end
  end

endmodule

// File: tb/tb_die_select_encoder.sv
// Directed self-checking bench for die_select_encoder; expectations are hand-computed codes.
module tb_die_select_encoder;
  import die_select_pkg::*;

  localparam int unsigned SYNC = 2;
`ifdef DIESEL_DEBOUNCE_EN
  localparam int unsigned DB = 4;
`else
  localparam int unsigned DB = 0;
`endif
  // Edges from an input change (set before edge k) until the output still shows the old value.
  localparam int unsigned HOLD_OLD = SYNC + DB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buttonD4, buttonD6, buttonD8, buttonD10, buttonD12, buttonD20, switchTest;
  logic [3:0] dieSelect;
  logic       selValid;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  die_select_encoder #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .buttonD4  (buttonD4),
    .buttonD6  (buttonD6),
    .buttonD8  (buttonD8),
    .buttonD10 (buttonD10),
    .buttonD12 (buttonD12),
    .buttonD20 (buttonD20),
    .switchTest(switchTest),
    .dieSelect (dieSelect),
    .selValid  (selValid)
  );

  // Observed/expected packed as {selValid, dieSelect}.
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got valid=%b code=%b, expected valid=%b code=%b",
                  tag, got[4], got[3:0], exp[4], exp[3:0]);
  endtask

  // Bit order: {test, D20, D12, D10, D8, D6, D4}
  task automatic set_buttons(input logic [6:0] v);
    @(negedge clk);
    {switchTest, buttonD20, buttonD12, buttonD10, buttonD8, buttonD6, buttonD4} = v;
  endtask

  task automatic edges(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [6:0] single_pat [7];
  logic [3:0] single_exp [7];

  initial begin
    single_pat = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                   7'b0010000, 7'b0100000, 7'b1000000};
    single_exp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7};

    rst_n = 1'b0;
    {switchTest, buttonD20, buttonD12, buttonD10, buttonD8, buttonD6, buttonD4} = '0;

    // Reset dominates a held D8 press
    set_buttons(7'b0000100);
    edges(2);
    check("reset_d8_held", {selValid, dieSelect}, {1'b0, 4'hF});

    // Release mid-press: fresh press, full latency from the first non-reset edge
    @(negedge clk);
    rst_n = 1'b1;
    edges(HOLD_OLD);
    check("rst_release_early", {selValid, dieSelect}, {1'b0, 4'hF});
    edges(1);
    check("rst_release_d8", {selValid, dieSelect}, {1'b1, 4'h2});

    // Single selects in turn
    for (int i = 0; i < 7; i++) begin
      set_buttons(single_pat[i]);
      edges(HOLD_OLD + 3);
      check($sformatf("single_%0d", i), {selValid, dieSelect}, {1'b1, single_exp[i]});
    end

    set_buttons(7'b0000000);
    edges(HOLD_OLD + 3);
    check("none", {selValid, dieSelect}, {1'b0, 4'hF});

    set_buttons(7'b0101010);
    edges(HOLD_OLD + 3);
    check("multi_d6_d10_d20", {selValid, dieSelect}, {1'b0, 4'hF});

    set_buttons(7'b1000001);
    edges(HOLD_OLD + 3);
    check("multi_test_d4", {selValid, dieSelect}, {1'b0, 4'hF});

    set_buttons(7'b1111111);
    edges(HOLD_OLD + 3);
    check("multi_all", {selValid, dieSelect}, {1'b0, 4'hF});

    // Latency: D12 press and release land exactly HOLD_OLD+1 edges after being driven
    set_buttons(7'b0000000);
    edges(HOLD_OLD + 3);
    set_buttons(7'b0010000);
    edges(HOLD_OLD);
    check("lat_press_before", {selValid, dieSelect}, {1'b0, 4'hF});
    edges(1);
    check("lat_press_at", {selValid, dieSelect}, {1'b1, 4'h4});
    edges(2);
    set_buttons(7'b0000000);
    edges(HOLD_OLD);
    check("lat_release_before", {selValid, dieSelect}, {1'b1, 4'h4});
    edges(1);
    check("lat_release_at", {selValid, dieSelect}, {1'b0, 4'hF});

`ifdef DIESEL_DEBOUNCE_EN
    // Short pulse must be rejected
    edges(4);
    set_buttons(7'b0000010);
    edges(3);
    set_buttons(7'b0000000);
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check($sformatf("db_short_%0d", i), {selValid, dieSelect}, {1'b0, 4'hF});
    end
    // Long pulse accepted after SYNC+DEBOUNCE edges
    set_buttons(7'b0000010);
    edges(SYNC + 4);
    check("db_long_before", {selValid, dieSelect}, {1'b0, 4'hF});
    edges(1);
    check("db_long_at", {selValid, dieSelect}, {1'b1, 4'h1});
    set_buttons(7'b0000000);
    edges(HOLD_OLD + 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/die_select_encoder.md
# die_select_encoder

Registered one-hot-to-binary encoder for the dice roller front panel. Takes six die-select buttons and a test switch, resynchronises them to `clk`, and drives a 4-bit `dieSelect` code to the roll logic. Any illegal combination (none pressed, or more than one pressed) yields the "no selection" code 4'b1111.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages in the input synchroniser. Legal range is ≥2.
- `DEBOUNCE_CYCLES`, default 4: stable-cycle count required before an input is accepted. Only used when `DIESEL_DEBOUNCE_EN` is defined. Legal range is ≥1.

Ports:
- `clk` input 1: single system clock, rising-edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `buttonD4` input 1: D4 select, active-high, asynchronous to `clk`.
- `buttonD6` input 1: D6 select.
- `buttonD8` input 1: D8 select.
- `buttonD10` input 1: D10 select.
- `buttonD12` input 1: D12 select.
- `buttonD20` input 1: D20 select.
- `switchTest` input 1: test-mode select.
- `dieSelect` output 4: encoded selection, registered.
- `selValid` output 1: high when `dieSelect` holds a legal (single-input) code, registered.

## Operation
- Each of the 7 inputs passes through its own `SYNC_STAGES`-deep synchroniser. With the macro defined, it then passes through a debouncer.
- The encoder counts the active conditioned inputs.
- If exactly one input is active, the code is:
  - D4 → 4'b0000
  - D6 → 4'b0001
  - D8 → 4'b0010
  - D10 → 4'b0011
  - D12 → 4'b0100
  - D20 → 4'b0101
  - test → 4'b0111
- Code 4'b0110 is never produced.
- If zero inputs are active, or two or more are active (any combination, test switch included), the code is 4'b1111. There is no priority.
- `selValid` is 1 exactly when the popcount is 1.
- `dieSelect` and `selValid` are updated every clock from the encoder. There is no hold or latch of the previous selection.

## Timing
- Reset: when `rst_n`=0 at a rising edge:
  - all synchroniser and debounce flops clear to 0 and all counters clear to 0;
  - `dieSelect` becomes 4'b1111 and `selValid` becomes 0.
- Reset dominates all inputs. Releasing reset mid-press is treated as a fresh press and sees the full latency below.
- Latency without debounce: an input stable before edge k is first visible on `dieSelect` after edge k+SYNC_STAGES. That is 3 edges with the default.
- Latency with debounce: add `DEBOUNCE_CYCLES` edges.
- Simultaneous transitions (one button released while another is pressed in the same cycle) may produce one intermediate 4'b1111 or multi-hot cycle. This is legal and must not be filtered.
- Output is glitch-free: both outputs come straight from flops.

## Configuration
- Macro: `DIESEL_DEBOUNCE_EN`.
- Defined:
  - each synchronised input feeds a per-input counter;
  - the debounced value changes only after the synchronised value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles;
  - any return to equality resets the counter to 0.
- Undefined: synchronised inputs feed the encoder directly, no counters are instantiated, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `die_select_pkg` holds:
  - code constants `DIE_D4`=4'h0, `DIE_D6`=4'h1, `DIE_D8`=4'h2, `DIE_D10`=4'h3, `DIE_D12`=4'h4, `DIE_D20`=4'h5, `DIE_TEST`=4'h7, `DIE_NONE`=4'hF;
  - a 4-bit code typedef;
  - an input-index enum (0..6).
- One sub-module, `die_input_cond`: a 1-bit synchroniser plus the optional debouncer, instantiated 7 times.
- The top module holds the encoder, popcount and output registers.

## Test plan
1. Reset: hold `rst_n`=0 for 2 cycles with `buttonD8`=1 → `dieSelect`=4'b1111, `selValid`=0. After release, 4'b0010 appears SYNC_STAGES+1 edges later.
2. Single selects, each held 5 cycles in turn (D4, D6, D8, D10, D12, D20, test) → 0000, 0001, 0010, 0011, 0100, 0101, 0111, each with `selValid`=1.
3. No input → 1111, `selValid`=0.
4. Multiple inputs, D6+D10+D20 → 1111, `selValid`=0. Test+D4 → 1111.
5. Latency: toggle `buttonD12` one cycle before edge k → change lands exactly at edge k+SYNC_STAGES.
6. With `DIESEL_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4:
   - a 3-cycle `buttonD6` pulse → output stays 1111;
   - a 6-cycle pulse → 0001 appears after SYNC_STAGES+4 edges.
